// File: rtl/led_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : led_sequencer                                                 |
// | Description : CSR-programmable status LED sequencer. Drives the active-low  |
// |               health LED with a 1 Hz heartbeat, a fast recovery blink, a    |
// |               power-off dark state, or software-selected N-pulse codes.     |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
module led_sequencer #(
  parameter logic [4:0] BASE_ADDR = 5'h1d,
  parameter logic [3:0] HB_TICKS  = 4'd8,
  parameter logic [3:0] GAP_TICKS = 4'd8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ce,
  input  logic [4:0] csr_a,
  input  logic [7:0] csr_di,
  input  logic       csr_we,
  output logic [7:0] csr_do,
  input  logic       pwr_enable,
  input  logic       force_recovery,
  output logic       led_n
);

  localparam logic [4:0] c_STAT_ADDR   = BASE_ADDR + 5'd1;
  localparam logic [3:0] c_PULSE_TICKS = 4'd2;
  // Only EN (bit 7) and COUNT (bits 3:0) are implemented in CTRL.
  localparam logic [7:0] c_CTRL_MASK   = 8'h8F;

  typedef enum logic [1:0] {
    S_HB  = 2'd0,
    S_ON  = 2'd1,
    S_OFF = 2'd2,
    S_GAP = 2'd3
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_ctrl;
  logic [3:0] r_tick;
  logic [3:0] w_tick_nxt;
  logic [3:0] r_idx;
  logic [3:0] w_idx_nxt;
  logic [3:0] r_snap;
  logic [3:0] w_snap_nxt;
  logic       r_led_n;
  logic       w_led_nxt;
  logic       r_rec_q;
  logic       w_code;
  logic       w_busy;

  assign w_code = r_ctrl[7] && (r_ctrl[3:0] != 4'd0);
  assign w_busy = (r_state != S_HB);
  assign led_n  = r_led_n;

  // CTRL register: write strobe lands on the same clk, unimplemented bits read 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ctrl <= 8'h00;
    end else if (csr_we && (csr_a == BASE_ADDR)) begin
      r_ctrl <= csr_di & c_CTRL_MASK;
    end
  end

  // Remember recovery state so its falling edge can restart the heartbeat dark.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rec_q <= 1'b0;
    end else begin
      r_rec_q <= force_recovery && pwr_enable;
    end
  end

  // Sequencer state, counters and registered LED drive.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_HB;
      r_tick  <= 4'd0;
      r_idx   <= 4'd0;
      r_snap  <= 4'd0;
      r_led_n <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_tick  <= w_tick_nxt;
      r_idx   <= w_idx_nxt;
      r_snap  <= w_snap_nxt;
      r_led_n <= w_led_nxt;
    end
  end

  // Next-state logic: power-off and recovery override the pattern FSM, and
  // losing code mode mid-sequence drops straight back to a dark heartbeat
  // without waiting for a ce tick.
  always_comb begin
    w_state_nxt = r_state;
    w_tick_nxt  = r_tick;
    w_idx_nxt   = r_idx;
    w_snap_nxt  = r_snap;
    w_led_nxt   = r_led_n;

    if (!pwr_enable) begin
      w_state_nxt = S_HB;
      w_tick_nxt  = 4'd0;
      w_idx_nxt   = 4'd0;
      w_snap_nxt  = 4'd0;
      w_led_nxt   = 1'b1;
    end else if (force_recovery) begin
      w_state_nxt = S_HB;
      w_tick_nxt  = 4'd0;
      w_idx_nxt   = 4'd0;
      if (ce) begin
        w_led_nxt = ~r_led_n;
      end
    end else if (r_rec_q || (w_busy && !w_code)) begin
      w_state_nxt = S_HB;
      w_tick_nxt  = 4'd0;
      w_idx_nxt   = 4'd0;
      w_led_nxt   = 1'b1;
    end else if (ce) begin
      case (r_state)
        S_HB: begin
          if (w_code) begin
            w_state_nxt = S_ON;
            w_tick_nxt  = 4'd0;
            w_idx_nxt   = 4'd1;
            w_snap_nxt  = r_ctrl[3:0];
            w_led_nxt   = 1'b0;
          end else if (r_tick == HB_TICKS - 4'd1) begin
            w_tick_nxt = 4'd0;
            w_led_nxt  = ~r_led_n;
          end else begin
            w_tick_nxt = r_tick + 4'd1;
          end
        end
        S_ON: begin
          if (r_tick == c_PULSE_TICKS - 4'd1) begin
            w_state_nxt = S_OFF;
            w_tick_nxt  = 4'd0;
            w_led_nxt   = 1'b1;
          end else begin
            w_tick_nxt = r_tick + 4'd1;
          end
        end
        S_OFF: begin
          if (r_tick == c_PULSE_TICKS - 4'd1) begin
            w_tick_nxt = 4'd0;
            if (r_idx < r_snap) begin
              w_state_nxt = S_ON;
              w_idx_nxt   = r_idx + 4'd1;
              w_led_nxt   = 1'b0;
            end else begin
              w_state_nxt = S_GAP;
              w_idx_nxt   = 4'd0;
              w_led_nxt   = 1'b1;
            end
          end else begin
            w_tick_nxt = r_tick + 4'd1;
          end
        end
        S_GAP: begin
          if (r_tick == GAP_TICKS - 4'd1) begin
            w_tick_nxt = 4'd0;
            if (w_code) begin
              w_state_nxt = S_ON;
              w_idx_nxt   = 4'd1;
              w_snap_nxt  = r_ctrl[3:0];
              w_led_nxt   = 1'b0;
            end else begin
              w_state_nxt = S_HB;
              w_led_nxt   = 1'b1;
            end
          end else begin
            w_tick_nxt = r_tick + 4'd1;
          end
        end
        default: begin
          w_state_nxt = S_HB;
          w_tick_nxt  = 4'd0;
          w_idx_nxt   = 4'd0;
          w_led_nxt   = 1'b1;
        end
      endcase
    end
  end

  // Read mux: zero when not addressed so it can be OR-ed into the shared bus.
  always_comb begin
    csr_do = 8'h00;
    if (csr_a == BASE_ADDR) begin
      csr_do = r_ctrl;
    end else if (csr_a == c_STAT_ADDR) begin
      csr_do = {w_busy, 3'b000, r_idx};
    end
  end

endmodule
`default_nettype wire
